// File: rtl/alu_pkg.sv
// Opcodes and sequencer states shared by the datapath ALU and the multiply sequencer.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OP_W  = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational datapath ALU; the multiply sequencer borrows it while busy.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] alu_control,
  output logic [WIDTH-1:0]    result
);

  localparam int unsigned SHW = $clog2(WIDTH);

  // Opcode decode; shift amount is the low bits of b.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      ALU_SHL: result = a << b[SHW-1:0];
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that performs every add/shift on the shared ALU.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_control,
  input  logic [WIDTH-1:0]    alu_result,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    product
);

  seq_state_e       state;
  seq_state_e       state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] product_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: abort cancels only while the loop is running; DONE always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_STEP;
      end
      S_STEP: begin
        if (abort)              state_nxt = S_IDLE;
        else if (mplier == '0)  state_nxt = S_DONE;
        else if (mplier[0])     state_nxt = S_SHIFT;
        else                    state_nxt = S_STEP;
      end
      S_SHIFT: begin
        if (abort) state_nxt = S_IDLE;
        else       state_nxt = S_STEP;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU drive and status; the ALU sees a harmless 0+0 whenever it is not needed.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_STEP: begin
        busy = 1'b1;
        if (mplier != '0) begin
          if (mplier[0]) begin
            alu_a       = acc;
            alu_b       = mcand;
            alu_control = ALU_ADD;
          end else begin
            alu_a       = mcand;
            alu_b       = WIDTH'(1);
            alu_control = ALU_SHL;
          end
        end
      end
      S_SHIFT: begin
        busy        = 1'b1;
        alu_a       = mcand;
        alu_b       = WIDTH'(1);
        alu_control = ALU_SHL;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, accumulate/shift updates from the ALU, and product latch on DONE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      product_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
          end
        end
        S_STEP: begin
          if (!abort && (mplier != '0)) begin
            if (mplier[0]) begin
              acc <= alu_result;
            end else begin
              mcand  <= alu_result;
              mplier <= mplier >> 1;
            end
          end
        end
        S_SHIFT: begin
          if (!abort) begin
            mcand  <= alu_result;
            mplier <= mplier >> 1;
          end
        end
        S_DONE:  product_q <= acc;
        default: ;
      endcase
    end
  end

  // During DONE the result is shown straight from acc so it is valid alongside done.
  assign product = (state == S_DONE) ? acc : product_q;

endmodule
